ipsxe_fft_test_seq: RTL and testbench

//  Test sequencer for the FFT core. Run: pulse the frame checker's start, send N_FRAMES frames into the

---
 rtl/ipsxe_fft_test_seq_if.sv | 23 ++
 rtl/ipsxe_fft_test_seq.sv | 187 ++++++++++++++++++
 tb/tb_ipsxe_fft_test_seq.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipsxe_fft_test_seq_if.sv
// Streaming interface between the FFT test sequencer and the FFT core:
// a config channel and a sample channel whose payload is a ROM index.
interface ipsxe_fft_test_seq_if #(
    parameter int LOG2_FFT_LEN = 4
);
    logic                    cfg_tvalid;
    logic [7:0]              cfg_tdata;
    logic                    cfg_tready;
    logic                    data_tvalid;
    logic                    data_tlast;
    logic [LOG2_FFT_LEN-1:0] sample_idx;
    logic                    data_tready;

    modport master (
        output cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, sample_idx,
        input  cfg_tready, data_tready
    );

    modport slave (
        input  cfg_tvalid, cfg_tdata, data_tvalid, data_tlast, sample_idx,
        output cfg_tready, data_tready
    );
endinterface

// File: rtl/ipsxe_fft_test_seq.sv
// FFT test sequencer: starts the frame checker, streams alternating FFT/IFFT
// frames into the core, waits for the checker and reports a sticky pass/fail.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  IDLE     | waiting for i_start
//  START    | checker start pulse, run counters cleared
//  CFG      | config beat for the current frame
//  DATA     | 2^LOG2_FFT_LEN sample beats
//  GAP      | FRAME_GAP idle enabled cycles between frames
//  WAIT_CHK | wait for checker finished (after it was seen low) or watchdog
//  FINAL    | one more cycle to capture the checker's last frame error
//  DONE     | done pulse, pass result published
module ipsxe_fft_test_seq #(
    parameter int LOG2_FFT_LEN   = 4,
    parameter int TEST_FRAME_NUM = 10,
    parameter int FRAME_GAP      = 0,
    parameter int WDOG_WIDTH     = 24
) (
    input  logic                 i_aclk,
    input  logic                 i_aresetn,
    input  logic                 i_aclken,
    input  logic                 i_start,
    ipsxe_fft_test_seq_if.master fft_if,
    output logic                 o_chk_start,
    input  logic                 i_chk_finished,
    input  logic                 i_chk_err,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass
);
    localparam int FRM_W = (TEST_FRAME_NUM > 1) ? $clog2(TEST_FRAME_NUM) : 1;
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [FRM_W-1:0]        FRM_LAST = FRM_W'(TEST_FRAME_NUM - 1);
    localparam logic [GAP_W-1:0]        GAP_LOAD = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam logic [LOG2_FFT_LEN-1:0] SMP_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CFG, S_DATA, S_GAP, S_WAIT_CHK, S_FINAL, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [FRM_W-1:0]        frm_cnt_q, frm_cnt_d;
    logic [LOG2_FFT_LEN-1:0] sample_cnt_q, sample_cnt_d;
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;
    logic [WDOG_WIDTH-1:0]   wdog_q, wdog_d, wdog_inc;
    logic                    err_sticky_q, err_sticky_d;
    logic                    seen_low_q, seen_low_d;
    logic                    cfg_tvalid_q, cfg_tvalid_d;
    logic                    cfg_fwd_q, cfg_fwd_d;
    logic                    data_tvalid_q, data_tvalid_d;
    logic                    data_tlast_q, data_tlast_d;
    logic                    chk_start_q, chk_start_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;

    always_comb begin
        state_d       = state_q;
        frm_cnt_d     = frm_cnt_q;
        sample_cnt_d  = sample_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        wdog_d        = wdog_q;
        err_sticky_d  = err_sticky_q;
        seen_low_d    = seen_low_q;
        cfg_tvalid_d  = cfg_tvalid_q;
        cfg_fwd_d     = cfg_fwd_q;
        data_tvalid_d = data_tvalid_q;
        data_tlast_d  = data_tlast_q;
        chk_start_d   = chk_start_q;
        busy_d        = busy_q;
        done_d        = done_q;
        pass_d        = pass_q;
        wdog_inc      = (&wdog_q) ? wdog_q : wdog_q + WDOG_WIDTH'(1);

        if (i_aclken) begin
            // START is excluded so a stale error from the previous run is dropped
            if (state_q inside {S_CFG, S_DATA, S_GAP, S_WAIT_CHK, S_FINAL})
                err_sticky_d = err_sticky_q | i_chk_err;

            case (state_q)
                S_IDLE: if (i_start) state_d = S_START;
                S_START: begin
                    frm_cnt_d    = '0;
                    sample_cnt_d = '0;
                    err_sticky_d = 1'b0;
                    seen_low_d   = 1'b0;
                    wdog_d       = '0;
                    state_d      = S_CFG;
                end
                S_CFG: if (fft_if.cfg_tready) state_d = S_DATA;
                S_DATA: begin
                    if (fft_if.data_tready) begin
                        sample_cnt_d = sample_cnt_q + LOG2_FFT_LEN'(1);
                        if (sample_cnt_q == SMP_LAST) begin
                            if (frm_cnt_q == FRM_LAST) begin
                                state_d = S_WAIT_CHK;
                            end else begin
                                frm_cnt_d = frm_cnt_q + FRM_W'(1);
                                if (FRAME_GAP > 0) begin
                                    gap_cnt_d = GAP_LOAD;
                                    state_d   = S_GAP;
                                end else begin
                                    state_d   = S_CFG;
                                end
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) state_d = S_CFG;
                    else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
                S_WAIT_CHK: begin
                    if (!i_chk_finished) seen_low_d = 1'b1;
                    wdog_d = wdog_inc;
                    if (seen_low_q && i_chk_finished) begin
                        state_d = S_FINAL;
                    end else if (&wdog_inc) begin
                        err_sticky_d = 1'b1;
                        state_d      = S_FINAL;
                    end
                end
                S_FINAL: state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase

            // Outputs are registered from the next state, so no ready->valid path exists
            cfg_tvalid_d  = (state_d == S_CFG);
            cfg_fwd_d     = (state_d == S_CFG) && !frm_cnt_d[0];
            data_tvalid_d = (state_d == S_DATA);
            data_tlast_d  = (state_d == S_DATA) && (sample_cnt_d == SMP_LAST);
            chk_start_d   = (state_d == S_START);
            busy_d        = !(state_d inside {S_IDLE, S_DONE});
            done_d        = (state_d == S_DONE);
            if (state_d == S_START)     pass_d = 1'b0;
            else if (state_d == S_DONE) pass_d = !err_sticky_d;
        end
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q       <= S_IDLE;
            frm_cnt_q     <= '0;
            sample_cnt_q  <= '0;
            gap_cnt_q     <= '0;
            wdog_q        <= '0;
            err_sticky_q  <= 1'b0;
            seen_low_q    <= 1'b0;
            cfg_tvalid_q  <= 1'b0;
            cfg_fwd_q     <= 1'b0;
            data_tvalid_q <= 1'b0;
            data_tlast_q  <= 1'b0;
            chk_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frm_cnt_q     <= frm_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            wdog_q        <= wdog_d;
            err_sticky_q  <= err_sticky_d;
            seen_low_q    <= seen_low_d;
            cfg_tvalid_q  <= cfg_tvalid_d;
            cfg_fwd_q     <= cfg_fwd_d;
            data_tvalid_q <= data_tvalid_d;
            data_tlast_q  <= data_tlast_d;
            chk_start_q   <= chk_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
        end
    end

    assign fft_if.cfg_tvalid  = cfg_tvalid_q;
    assign fft_if.cfg_tdata   = {7'b0, cfg_fwd_q};
    assign fft_if.data_tvalid = data_tvalid_q;
    assign fft_if.data_tlast  = data_tlast_q;
    assign fft_if.sample_idx  = sample_cnt_q;
    assign o_chk_start        = chk_start_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_pass             = pass_q;
endmodule

// File: tb/tb_ipsxe_fft_test_seq.sv
// Bench for ipsxe_fft_test_seq: transaction-level model of the run (frame order,
// sample indices, gaps, run result) checked every cycle, plus directed scenarios.
module tb_ipsxe_fft_test_seq;
    localparam int LOG2   = 4;
    localparam int N      = 16;
    localparam int FRAMES = 10;
    localparam int GAP    = 3;
    localparam int WDW    = 8;

    logic clk = 1'b0;
    logic rst_n, en, start, chk_finished, chk_err;
    logic chk_start, busy, done, pass;

    ipsxe_fft_test_seq_if #(.LOG2_FFT_LEN(LOG2)) bus ();

    ipsxe_fft_test_seq #(
        .LOG2_FFT_LEN(LOG2), .TEST_FRAME_NUM(FRAMES), .FRAME_GAP(GAP), .WDOG_WIDTH(WDW)
    ) dut (
        .i_aclk(clk), .i_aresetn(rst_n), .i_aclken(en), .i_start(start),
        .fft_if(bus),
        .o_chk_start(chk_start), .i_chk_finished(chk_finished), .i_chk_err(chk_err),
        .o_busy(busy), .o_done(done), .o_pass(pass)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // scenario controls
    bit bp_mode = 1'b0, stuck_mode = 1'b0, tog = 1'b0, exp_pass = 1'b1;

    // model state
    int  run_cfg, run_samp, run_lasts, sif, gap_cnt, wcnt;
    bit  gap_pending, fin_pending, in_run, pass_model, prev_ok;
    int  n_starts = 0, n_dones = 0;
    int  last_cfg, last_samp, last_lasts, last_wcnt;
    logic [18:0] prev_vec;
    logic [8:0]  prev_cfg;
    logic [5:0]  prev_data;
    bit  prev_en, prev_cfg_hs, prev_data_hs;

    logic [18:0] out_vec;
    assign out_vec = {chk_start, busy, done, pass, bus.cfg_tvalid, bus.cfg_tdata,
                      bus.data_tvalid, bus.data_tlast, bus.sample_idx};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    // Input drivers and checker model, updated just after each rising edge
    initial begin
        int fdly;
        fdly = 0;
        bus.cfg_tready = 1'b1;
        bus.data_tready = 1'b1;
        en = 1'b1;
        chk_finished = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.cfg_tready  = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.data_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            en = tog ? ~en : 1'b1;
            if (stuck_mode) begin
                chk_finished = 1'b1;
            end else if (chk_start) begin
                chk_finished = 1'b0;
                fdly = 4;
            end else if (!chk_finished && run_lasts == FRAMES) begin
                if (fdly == 0) chk_finished = 1'b1;
                else           fdly--;
            end
        end
    end

    // Compare process: sampled on the falling edge, predicts the coming rising edge
    initial begin
        bit cfg_hs, data_hs;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_outputs", int'(out_vec), 0);
                in_run = 0; pass_model = 0; prev_ok = 0;
                gap_pending = 0; fin_pending = 0;
                run_cfg = 0; run_samp = 0; run_lasts = 0; sif = 0;
            end else begin
                cfg_hs  = en && bus.cfg_tvalid && bus.cfg_tready;
                data_hs = en && bus.data_tvalid && bus.data_tready;
                if (prev_ok && !prev_en)
                    check("hold_when_disabled", int'(out_vec), int'(prev_vec));
                if (prev_ok && prev_cfg[8] && !prev_cfg_hs)
                    check("cfg_stall_hold", int'({bus.cfg_tvalid, bus.cfg_tdata}), int'(prev_cfg));
                if (prev_ok && prev_data[5] && !prev_data_hs)
                    check("data_stall_hold",
                          int'({bus.data_tvalid, bus.data_tlast, bus.sample_idx}), int'(prev_data));
                check("single_valid", int'(bus.cfg_tvalid & bus.data_tvalid), 0);

                if (chk_start) begin
                    if (en) n_starts++;
                    in_run = 1; pass_model = 0;
                    run_cfg = 0; run_samp = 0; run_lasts = 0; sif = 0;
                    gap_pending = 0; fin_pending = 0;
                end
                if (fin_pending && !done && en) wcnt++;
                if (done) begin
                    if (en) n_dones++;
                    check("done_cfg_beats", run_cfg, FRAMES);
                    check("done_samples", run_samp, FRAMES * N);
                    if (fin_pending) begin
                        last_wcnt = wcnt;
                        if (stuck_mode) check("wdog_cycles", wcnt, (1 << WDW));
                    end
                    last_cfg = run_cfg; last_samp = run_samp; last_lasts = run_lasts;
                    fin_pending = 0; in_run = 0; pass_model = exp_pass;
                end
                check("busy", int'(busy), int'(in_run));
                check("pass", int'(pass), int'(pass_model));
                if (!in_run)
                    check("valid_outside_run", int'(bus.cfg_tvalid | bus.data_tvalid), 0);

                if (gap_pending) begin
                    if (bus.cfg_tvalid) begin
                        check("frame_gap", gap_cnt, GAP);
                        gap_pending = 0;
                    end else if (en && !bus.data_tvalid) begin
                        gap_cnt++;
                    end
                end
                if (cfg_hs) begin
                    check("cfg_order", run_cfg, run_lasts);
                    check("cfg_tdata", int'(bus.cfg_tdata), (run_cfg % 2 == 0) ? 1 : 0);
                    run_cfg++;
                end
                if (data_hs) begin
                    check("data_order", run_cfg, run_lasts + 1);
                    check("sample_idx", int'(bus.sample_idx), sif);
                    check("tlast", int'(bus.data_tlast), (sif == N - 1) ? 1 : 0);
                    run_samp++;
                    if (sif == N - 1) begin
                        sif = 0;
                        run_lasts++;
                        if (run_lasts < FRAMES) begin
                            gap_pending = 1; gap_cnt = 0;
                        end else begin
                            fin_pending = 1; wcnt = 0;
                        end
                    end else begin
                        sif++;
                    end
                end
                prev_ok = 1; prev_en = en; prev_vec = out_vec;
                prev_cfg = {bus.cfg_tvalid, bus.cfg_tdata};
                prev_data = {bus.data_tvalid, bus.data_tlast, bus.sample_idx};
                prev_cfg_hs = cfg_hs; prev_data_hs = data_hs;
            end
        end
    end

    task automatic run_start();
        @(posedge clk); #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) check(nm, 0, 1);
    endtask

    task automatic wait_model(input int lasts, input int s, input string nm);
        int k;
        k = 0;
        while (!(run_lasts == lasts && sif == s && bus.data_tvalid) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 2000) check(nm, 0, 1);
    endtask

    initial begin
        int d0, s0, k;
        rst_n = 1'b0; start = 1'b0; chk_err = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_state", int'(out_vec), 0);
        repeat (2) @(posedge clk);
        #1;

        // 1: clean run; checker error still high from before is ignored at START
        d0 = n_dones; exp_pass = 1; chk_err = 1'b1; start = 1'b1;
        k = 0;
        while (!chk_start && k < 20) begin @(posedge clk); #1; k++; end
        check("t1_chk_start_seen", int'(chk_start), 1);
        start = 1'b0;
        @(posedge clk); #1 chk_err = 1'b0;
        wait_done(1000, "t1_timeout");
        repeat (2) @(negedge clk);
        check("t1_pass", int'(pass), 1);
        check("t1_dones", n_dones - d0, 1);
        check("t1_cfg_beats", last_cfg, 10);
        check("t1_samples", last_samp, 160);
        check("t1_tlasts", last_lasts, 10);

        // 2: random backpressure on both channels
        d0 = n_dones; bp_mode = 1;
        run_start();
        wait_done(4000, "t2_timeout");
        bp_mode = 0;
        repeat (2) @(negedge clk);
        check("t2_pass", int'(pass), 1);
        check("t2_samples", last_samp, 160);
        check("t2_dones", n_dones - d0, 1);

        // 3: one-cycle checker error mid frame 3, then a clean run
        exp_pass = 0;
        run_start();
        wait_model(2, 5, "t3_reach_frame3");
        chk_err = 1'b1;
        @(posedge clk); #1 chk_err = 1'b0;
        wait_done(1000, "t3_timeout");
        repeat (2) @(negedge clk);
        check("t3_pass_err", int'(pass), 0);
        exp_pass = 1;
        run_start();
        wait_done(1000, "t3b_timeout");
        repeat (2) @(negedge clk);
        check("t3_pass_clean", int'(pass), 1);

        // 4: finished never drops -> watchdog
        stuck_mode = 1; exp_pass = 0;
        run_start();
        wait_done(3000, "t4_timeout");
        repeat (2) @(negedge clk);
        check("t4_pass", int'(pass), 0);
        check("t4_wdog_cycles", last_wcnt, 256);
        stuck_mode = 0;

        // 5: reset during frame 5, then a clean run
        exp_pass = 1; d0 = n_dones;
        run_start();
        wait_model(4, 3, "t5_reach_frame5");
        rst_n = 1'b0;
        #1 check("t5_rst_outs", int'(out_vec), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("t5_no_done", n_dones - d0, 0);
        run_start();
        wait_done(1000, "t5_timeout");
        repeat (2) @(negedge clk);
        check("t5_pass", int'(pass), 1);
        check("t5_dones", n_dones - d0, 1);
        check("t5_samples", last_samp, 160);

        // 6: clock enable toggling, start re-pulsed while busy
        tog = 1; d0 = n_dones; s0 = n_starts;
        run_start();
        repeat (30) @(posedge clk);
        #1 start = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        check("t6_busy_mid", int'(busy), 1);
        wait_done(6000, "t6_timeout");
        tog = 0;
        repeat (2) @(negedge clk);
        check("t6_starts", n_starts - s0, 1);
        check("t6_dones", n_dones - d0, 1);
        check("t6_pass", int'(pass), 1);
        check("t6_cfg_beats", last_cfg, 10);
        check("t6_samples", last_samp, 160);

        // start coinciding with the done cycle is ignored
        s0 = n_starts;
        run_start();
        wait_done(1000, "t6b_timeout");
        check("t6b_en_at_done", int'(en), 1);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6b_start_on_done", n_starts - s0, 1);
        check("t6b_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running, expected finished");
        $fatal(1, "global timeout");
    end
endmodule
